square_seq: RTL



---
 rtl/square_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/square_seq.sv
// square_seq
// Sequential fixed-point squarer. It takes an unsigned Q(W/2-2).8 root
// (Q4.8 at the default W=12) and produces its exact unsigned square
// (Q8.16 at default) with a shift-add multiplier that runs one step per
// clock for W clocks. It also produces a rounded (half-up), saturated 8-bit
// integer view of the square.
//
// Ports:
//   clk      in   1    system clock, rising edge
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    request, only looked at while idle
//   root_in  in   W    operand, captured on the accepted start edge
//   busy     out  1    high while the multiply steps are running
//   done     out  1    one-cycle pulse when sq_out/int_out update
//   sq_out   out  2W   exact square
//   int_out  out  8    top 8 bits of sq_out rounded on the next bit, saturated to 0xFF
module square_seq #(
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   root_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] sq_out,
    output logic [7:0]     int_out
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   sq_q, sq_d;
    logic [7:0]      int_q, int_d;

    // Integer view of the accumulator: the top byte plus the first fraction
    // bit for half-up rounding. A top byte of 0xFF must not wrap to zero
    // when rounding up, so it is pinned at 0xFF.
    logic [7:0] acc_top;
    logic       acc_round;
    logic [7:0] acc_int;

    always_comb begin
        acc_top   = acc_q[PW-1 -: 8];
        acc_round = acc_q[PW-9];
        acc_int   = (acc_top == 8'hFF) ? 8'hFF : acc_top + {7'd0, acc_round};
    end

    // Next-state and datapath logic. busy/done are computed for the state we
    // are entering so that the registered outputs line up with that state.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sq_d     = sq_q;
        int_d    = int_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{(PW-W){1'b0}}, root_in};
                    mplier_d = root_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                    busy_d   = 1'b1;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                sq_d    = acc_q;
                int_d   = acc_int;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the outputs, lives here; reset aborts any
    // computation in flight without producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sq_q     <= '0;
            int_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sq_q     <= sq_d;
            int_q    <= int_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sq_out  = sq_q;
    assign int_out = int_q;

endmodule
